// File: rtl/regfile_pkg.sv
// Shared sizes and types for the integer register file and its pending-write scoreboard.
package regfile_pkg;
    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // A source is still pending if its count stays nonzero after this cycle's write-back retires one.
    function automatic logic pending_after_wb(cnt_t c, logic wb_hit);
        cnt_t eff;
        eff = (wb_hit && c != '0) ? c - cnt_t'(1) : c;
        return eff != '0;
    endfunction
endpackage

// File: rtl/regfile_if.sv
// Register file bundle: write-back, two read ports, issue scoreboard, flush and debug read.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN
);
    logic            i_rd_wen;
    reg_addr_t       i_rd_addr;
    logic [XLEN-1:0] i_rd_wdata;
    logic            i_rs1_ren;
    logic            i_rs2_ren;
    reg_addr_t       i_rs1_addr;
    reg_addr_t       i_rs2_addr;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic            o_rs1_busy;
    logic            o_rs2_busy;
    logic            i_issue_valid;
    reg_addr_t       i_issue_rd;
    logic            o_issue_stall;
    logic            i_flush;
    reg_addr_t       i_dbg_addr;
    logic [XLEN-1:0] o_dbg_data;

    modport master (
        output i_rd_wen, i_rd_addr, i_rd_wdata, i_rs1_ren, i_rs2_ren, i_rs1_addr, i_rs2_addr,
               i_issue_valid, i_issue_rd, i_flush, i_dbg_addr,
        input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_stall, o_dbg_data
    );

    modport slave (
        input  i_rd_wen, i_rd_addr, i_rd_wdata, i_rs1_ren, i_rs2_ren, i_rs1_addr, i_rs2_addr,
               i_issue_valid, i_issue_rd, i_flush, i_dbg_addr,
        output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_stall, o_dbg_data
    );
endinterface

// File: rtl/regfile_sb_counter.sv
// Saturating 0..3 count of in-flight producers for one architectural register.
module sb_counter
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic flush,
    output cnt_t cnt
);
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + cnt_t'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - cnt_t'(1);
        end
    end
endmodule

// File: rtl/regfile.sv
// Integer register file (x0 hardwired to zero) with write-back bypass and a per-register issue scoreboard.
module regfile
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input logic       clock,
    input logic       reset,
    regfile_if.slave  rf
);
    logic [XLEN-1:0] regs [NREG];
    cnt_t            cnt  [NREG];
    logic            wb_en;
    logic            issue_fire;
    logic            stall;

    assign wb_en = rf.i_rd_wen && rf.i_rd_addr != '0;

    // NOTE: the array is reset explicitly because reads after reset must return zero, not stale data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_en) begin
            regs[rf.i_rd_addr] <= rf.i_rd_wdata;
        end
    end

    // A saturated destination may still issue when a write-back frees a slot in the same cycle.
    assign stall = rf.i_issue_valid && rf.i_issue_rd != '0
                && cnt[rf.i_issue_rd] == cnt_t'(CNT_MAX)
                && !(wb_en && rf.i_rd_addr == rf.i_issue_rd);

    assign issue_fire = rf.i_issue_valid && rf.i_issue_rd != '0 && !stall && !rf.i_flush;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        sb_counter u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (issue_fire && rf.i_issue_rd == reg_addr_t'(r)),
            .dec   (wb_en && rf.i_rd_addr == reg_addr_t'(r)),
            .flush (rf.i_flush),
            .cnt   (cnt[r])
        );
    end

    // Outputs are forced low during reset so a bypassed write cannot leak through.
    // NOTE: every output gets a default first so this block never infers a latch.
    always_comb begin
        rf.o_rs1_data    = '0;
        rf.o_rs2_data    = '0;
        rf.o_rs1_busy    = 1'b0;
        rf.o_rs2_busy    = 1'b0;
        rf.o_issue_stall = 1'b0;
        rf.o_dbg_data    = '0;
        if (!reset) begin
            if (rf.i_rs1_ren && rf.i_rs1_addr != '0) begin
                rf.o_rs1_data = (wb_en && rf.i_rd_addr == rf.i_rs1_addr) ? rf.i_rd_wdata
                                                                          : regs[rf.i_rs1_addr];
                rf.o_rs1_busy = pending_after_wb(cnt[rf.i_rs1_addr],
                                                 wb_en && rf.i_rd_addr == rf.i_rs1_addr);
            end
            if (rf.i_rs2_ren && rf.i_rs2_addr != '0) begin
                rf.o_rs2_data = (wb_en && rf.i_rd_addr == rf.i_rs2_addr) ? rf.i_rd_wdata
                                                                          : regs[rf.i_rs2_addr];
                rf.o_rs2_busy = pending_after_wb(cnt[rf.i_rs2_addr],
                                                 wb_en && rf.i_rd_addr == rf.i_rs2_addr);
            end
            if (rf.i_dbg_addr != '0) begin
                rf.o_dbg_data = regs[rf.i_dbg_addr];
            end
            rf.o_issue_stall = stall;
        end
    end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning register data width.
REQ-002 SHALL have parameter NREG, default 32, meaning number of architectural registers (address width 5).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_rd_wen, input, 1, write-back write enable.
REQ-006 SHALL have port i_rd_addr, input, 5, write-back destination register.
REQ-007 SHALL have port i_rd_wdata, input, XLEN, write-back data.
REQ-008 SHALL have ports i_rs1_ren and i_rs2_ren, input, 1 each, read-port enables.
REQ-009 SHALL have ports i_rs1_addr and i_rs2_addr, input, 5 each, read addresses.
REQ-010 SHALL have ports o_rs1_data and o_rs2_data, output, XLEN each, read data.
REQ-011 SHALL have ports o_rs1_busy and o_rs2_busy, output, 1 each, source has an unretired producer.
REQ-012 SHALL have port i_issue_valid, input, 1, an instruction with a destination issues this cycle.
REQ-013 SHALL have port i_issue_rd, input, 5, destination of the issuing instruction.
REQ-014 SHALL have port o_issue_stall, output, 1, issue refused because the destination counter is saturated.
REQ-015 SHALL have port i_flush, input, 1, pipeline flush; clears all pending counts.
REQ-016 SHALL have port i_dbg_addr, input, 5, and port o_dbg_data, output, XLEN, combinational debug/difftest read.

Function
REQ-017 Write: on clock edge with i_rd_wen=1 and i_rd_addr!=0, regs[i_rd_addr] SHALL take i_rd_wdata; writes to x0 SHALL be discarded.
REQ-018 Read: o_rsN_data SHALL be combinational, 0 when i_rsN_ren=0 or i_rsN_addr=0, else regs[i_rsN_addr].
REQ-019 Bypass: when i_rd_wen=1, i_rd_addr=i_rsN_addr!=0 and ren=1, o_rsN_data SHALL equal i_rd_wdata in the same cycle.
REQ-020 o_dbg_data SHALL return regs[i_dbg_addr] without bypass; 0 for address 0.
REQ-021 Each register 1..31 SHALL own a 2-bit pending counter cnt[r] (0..3); cnt[0] SHALL be constantly 0.
REQ-022 Issue (i_issue_valid=1, i_issue_rd!=0, not stalled, i_flush=0) SHALL increment cnt[i_issue_rd].
REQ-023 Write-back (i_rd_wen=1, i_rd_addr!=0, cnt>0) SHALL decrement cnt[i_rd_addr]; write-back with cnt=0 SHALL leave it 0 and still write data.
REQ-024 Issue and write-back to the same register in one cycle SHALL leave cnt unchanged.
REQ-025 o_issue_stall SHALL be 1 combinationally when i_issue_valid=1, i_issue_rd!=0 and cnt[i_issue_rd]=3 with no same-cycle write-back to it; the stalled issue SHALL not change cnt.
REQ-026 o_rsN_busy SHALL equal ren and addr!=0 and (cnt[addr] minus 1 if same-cycle write-back hits addr, else cnt[addr]) != 0.
REQ-027 i_flush=1 SHALL zero every cnt on the next edge, overriding same-cycle issue and write-back counter effects; the register write itself SHALL still occur.
REQ-028 Latency: register and counter updates visible on reads one cycle after the edge; bypass makes write data visible in the write cycle.

Reset
REQ-029 reset=1 SHALL asynchronously clear all regs and all cnt to 0, independent of clock.
REQ-030 During reset all outputs SHALL be 0 (data 0, busy 0, stall 0); writes and issues presented during reset SHALL be lost.
REQ-031 Reset deassertion mid-operation SHALL resume with an empty scoreboard; no pending state survives.

Structure
REQ-032 XLEN, NREG, register-address width and counter max (3) SHALL live in the shared defines package.
REQ-033 The per-register pending counter SHALL be one sub-module, sb_counter, instantiated for registers 1..31.

Verification
REQ-034 Write x5=0xDEAD_BEEF_0000_0001, read rs1=5 next cycle -> o_rs1_data=0xDEADBEEF00000001; same-cycle read -> bypassed same value.
REQ-035 Write x0=0xFFFF..., read rs2=0 and dbg=0 -> both 0; no busy.
REQ-036 Issue rd=7 three times -> cnt=3, o_rs1_busy=1 for rs1=7; 4th issue -> o_issue_stall=1, cnt stays 3; 4th issue plus write-back x7 same cycle -> no stall, cnt 3.
REQ-037 cnt[9]=1, write-back x9 with rs1=9 read same cycle -> o_rs1_busy=0, data=wdata; cnt[9]=2 -> busy stays 1.
REQ-038 cnt[3]=2, cnt[4]=1, i_flush with issue rd=3 -> all cnt 0 next cycle, busy 0.
REQ-039 Assert reset asynchronously between edges with regs nonzero -> all outputs 0 immediately; after release, reads return 0.
